arbiter_nx1: RTL and testbench

//  N-master to 1-slave bus arbiter for multi-hart tops; successor of the fixed 2-master arbiter.

---
 rtl/arvi_arb_pkg.sv | 11 +
 rtl/arbiter_nx1_rr_pick.sv | 41 ++++
 rtl/arbiter_nx1.sv | 143 ++++++++++++++
 tb/tb_arbiter_nx1.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_arb_pkg.sv
// Shared types and helpers for the bus arbiter family.
package arvi_arb_pkg;

  typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_e;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  function automatic int id_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbiter_nx1_rr_pick.sv
// Combinational rotating picker: first set request at or after ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);
  localparam int SW = PW + 1;

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [PW-1:0]  off;
  logic [SW-1:0]  sum;

  // Doubling the request vector turns the wrap into a plain part-select.
  assign req2 = {req_i, req_i};
  assign rot  = req2[ptr_i +: N];

  always_comb begin
    off   = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = PW'(k);
        any_o = 1'b1;
      end
    end
  end

  assign sum   = {1'b0, ptr_i} + {1'b0, off};
  assign idx_o = (sum >= SW'(N)) ? PW'(sum - SW'(N)) : sum[PW-1:0];

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant_o[gi] = any_o && (idx_o == PW'(gi));
  end

endmodule

// File: rtl/arbiter_nx1.sv
// N-master to 1-slave bus arbiter: grants one master per transaction, forwards its
// captured request with the master ID, and routes the slave ack back to the owner.
module arbiter_nx1
  import arvi_arb_pkg::*;
#(
  parameter int        N_MASTERS = 2,
  parameter arb_mode_e ARB_MODE  = ARB_RR,
  parameter int        XLEN      = 32,
  parameter int        ID_W      = id_width(N_MASTERS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_MASTERS-1:0]   i_bus_en,
  input  logic [N_MASTERS-1:0]   i_wr_en,
  input  logic [N_MASTERS*XLEN-1:0] i_wr_data,
  input  logic [N_MASTERS*XLEN-1:0] i_addr,
  input  logic [N_MASTERS*4-1:0] i_byte_en,
  input  logic [N_MASTERS-1:0]   i_atomic,
  input  logic [N_MASTERS*7-1:0] i_operation,
  input  logic [N_MASTERS-1:0]   i_lock,
  output logic [N_MASTERS-1:0]   o_ack,
  output logic [XLEN-1:0]        o_rd_data,
  input  logic                   i_ack,
  input  logic [XLEN-1:0]        i_rd_data,
  output logic                   o_bus_en,
  output logic                   o_wr_en,
  output logic [XLEN-1:0]        o_wr_data,
  output logic [XLEN-1:0]        o_addr,
  output logic [3:0]             o_byte_en,
  output logic                   o_atomic,
  output logic [6:0]             o_operation,
  output logic [ID_W-1:0]        o_id
);

  arb_state_e state_q;
  logic [ID_W-1:0] id_q, ptr_q, ptr_d, lock_owner_q, win_idx, pick_ptr;
  logic            lock_valid_q, lock_cap_q, win_any, ack_fire;
  logic [N_MASTERS-1:0] req_eff, owner_mask, win_grant;

  logic            wr_en_q, atomic_q;
  logic [XLEN-1:0] wr_data_q, addr_q;
  logic [3:0]      byte_en_q;
  logic [6:0]      op_q;

  logic            sel_wr_en, sel_atomic, sel_lock;
  logic [XLEN-1:0] sel_wr_data, sel_addr;
  logic [3:0]      sel_byte_en;
  logic [6:0]      sel_op;

  assign ack_fire = (state_q == BUSY) && i_ack;

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
    assign owner_mask[gi] = (lock_owner_q == ID_W'(gi));
    assign o_ack[gi]      = ack_fire && (id_q == ID_W'(gi));
  end

  // While a lock is held only the owner may win, even if it is not requesting.
  assign req_eff  = lock_valid_q ? (i_bus_en & owner_mask) : i_bus_en;
  assign pick_ptr = (ARB_MODE == ARB_FIXED) ? '0 : ptr_q;
  assign ptr_d    = (id_q == ID_W'(N_MASTERS - 1)) ? '0 : id_q + ID_W'(1);

  rr_pick #(.N(N_MASTERS), .PW(ID_W)) u_pick (
    .req_i   (req_eff),
    .ptr_i   (pick_ptr),
    .grant_o (win_grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  always_comb begin
    sel_wr_en   = 1'b0;
    sel_wr_data = '0;
    sel_addr    = '0;
    sel_byte_en = '0;
    sel_atomic  = 1'b0;
    sel_op      = '0;
    sel_lock    = 1'b0;
    for (int m = 0; m < N_MASTERS; m++) begin
      if (win_grant[m]) begin
        sel_wr_en   = i_wr_en[m];
        sel_wr_data = i_wr_data[m*XLEN +: XLEN];
        sel_addr    = i_addr[m*XLEN +: XLEN];
        sel_byte_en = i_byte_en[m*4 +: 4];
        sel_atomic  = i_atomic[m];
        sel_op      = i_operation[m*7 +: 7];
        sel_lock    = i_lock[m];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      id_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      addr_q       <= '0;
      byte_en_q    <= '0;
      atomic_q     <= 1'b0;
      op_q         <= '0;
      lock_cap_q   <= 1'b0;
      ptr_q        <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_any) begin
            state_q    <= BUSY;
            id_q       <= win_idx;
            wr_en_q    <= sel_wr_en;
            wr_data_q  <= sel_wr_data;
            addr_q     <= sel_addr;
            byte_en_q  <= sel_byte_en;
            atomic_q   <= sel_atomic;
            op_q       <= sel_op;
            lock_cap_q <= sel_lock;
          end
        end
        BUSY: begin
          if (i_ack) begin
            state_q      <= IDLE;
            if (ARB_MODE == ARB_RR) ptr_q <= ptr_d;
            lock_valid_q <= lock_cap_q;
            lock_owner_q <= id_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_bus_en    = (state_q == BUSY);
  assign o_id        = id_q;
  assign o_wr_en     = wr_en_q;
  assign o_wr_data   = wr_data_q;
  assign o_addr      = addr_q;
  assign o_byte_en   = byte_en_q;
  assign o_atomic    = atomic_q;
  assign o_operation = op_q;
  assign o_rd_data   = ack_fire ? i_rd_data : '0;

endmodule

// File: tb/tb_arbiter_nx1.sv
// Directed self-checking bench: 4-master RR, 4-master FIXED and 3-master RR instances.
module tb_arbiter_nx1;
  import arvi_arb_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]        ben  [3];
  logic              sack [3];
  logic [XLEN-1:0]   srd;
  logic [3:0]        wr_en, atomic, lock;
  logic [4*XLEN-1:0] wr_data, addr;
  logic [15:0]       byte_en;
  logic [27:0]       oper;

  wire            o_ben  [3];
  wire [1:0]      o_id   [3];
  wire [3:0]      o_ack  [3];
  wire [XLEN-1:0] o_addr [3];
  wire [XLEN-1:0] o_rd   [3];
  wire            o_wen  [3];
  wire [XLEN-1:0] o_wd   [3];
  wire [3:0]      o_be   [3];
  wire            o_at   [3];
  wire [6:0]      o_op   [3];
  wire [2:0]      ack3;
  assign o_ack[2] = {1'b0, ack3};

  arbiter_nx1 #(.N_MASTERS(4), .ARB_MODE(ARB_RR), .XLEN(XLEN)) dut_rr (
    .i_clk(clk), .i_rst(rst), .i_bus_en(ben[0]), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_addr(addr), .i_byte_en(byte_en), .i_atomic(atomic), .i_operation(oper), .i_lock(lock),
    .o_ack(o_ack[0]), .o_rd_data(o_rd[0]), .i_ack(sack[0]), .i_rd_data(srd),
    .o_bus_en(o_ben[0]), .o_wr_en(o_wen[0]), .o_wr_data(o_wd[0]), .o_addr(o_addr[0]),
    .o_byte_en(o_be[0]), .o_atomic(o_at[0]), .o_operation(o_op[0]), .o_id(o_id[0])
  );

  arbiter_nx1 #(.N_MASTERS(4), .ARB_MODE(ARB_FIXED), .XLEN(XLEN)) dut_fx (
    .i_clk(clk), .i_rst(rst), .i_bus_en(ben[1]), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_addr(addr), .i_byte_en(byte_en), .i_atomic(atomic), .i_operation(oper), .i_lock(lock),
    .o_ack(o_ack[1]), .o_rd_data(o_rd[1]), .i_ack(sack[1]), .i_rd_data(srd),
    .o_bus_en(o_ben[1]), .o_wr_en(o_wen[1]), .o_wr_data(o_wd[1]), .o_addr(o_addr[1]),
    .o_byte_en(o_be[1]), .o_atomic(o_at[1]), .o_operation(o_op[1]), .o_id(o_id[1])
  );

  arbiter_nx1 #(.N_MASTERS(3), .ARB_MODE(ARB_RR), .XLEN(XLEN)) dut_n3 (
    .i_clk(clk), .i_rst(rst), .i_bus_en(ben[2][2:0]), .i_wr_en(wr_en[2:0]),
    .i_wr_data(wr_data[3*XLEN-1:0]), .i_addr(addr[3*XLEN-1:0]), .i_byte_en(byte_en[11:0]),
    .i_atomic(atomic[2:0]), .i_operation(oper[20:0]), .i_lock(lock[2:0]),
    .o_ack(ack3), .o_rd_data(o_rd[2]), .i_ack(sack[2]), .i_rd_data(srd),
    .o_bus_en(o_ben[2]), .o_wr_en(o_wen[2]), .o_wr_data(o_wd[2]), .o_addr(o_addr[2]),
    .o_byte_en(o_be[2]), .o_atomic(o_at[2]), .o_operation(o_op[2]), .o_id(o_id[2])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a grant on instance d, check it is master id, ack it, check the return path.
  task automatic txn(input int d, input int id, input bit drop);
    int cyc = 0;
    while (o_ben[d] !== 1'b1 && cyc < 20) begin
      tick;
      cyc++;
    end
    chk($sformatf("d%0d_busy", d), 64'(o_ben[d]), 64'd1);
    chk($sformatf("d%0d_id", d), 64'(o_id[d]), 64'(id));
    chk($sformatf("d%0d_addr", d), 64'(o_addr[d]), 64'(addr[id*XLEN +: XLEN]));
    chk($sformatf("d%0d_wdata", d), 64'(o_wd[d]), 64'(wr_data[id*XLEN +: XLEN]));
    chk($sformatf("d%0d_wen", d), 64'(o_wen[d]), 64'(wr_en[id]));
    chk($sformatf("d%0d_be", d), 64'(o_be[d]), 64'(byte_en[id*4 +: 4]));
    chk($sformatf("d%0d_atomic", d), 64'(o_at[d]), 64'(atomic[id]));
    chk($sformatf("d%0d_op", d), 64'(o_op[d]), 64'(oper[id*7 +: 7]));
    srd     = 32'hD000_0000 | 32'(d << 8) | 32'(id);
    sack[d] = 1'b1;
    #1;
    chk($sformatf("d%0d_ack", d), 64'(o_ack[d]), 64'(4'b0001 << id));
    chk($sformatf("d%0d_rd", d), 64'(o_rd[d]), 64'(srd));
    tick;
    sack[d] = 1'b0;
    if (drop) ben[d][id] = 1'b0;
    chk($sformatf("d%0d_idle", d), 64'(o_ben[d]), 64'd0);
    $display("txn dut%0d master%0d addr=%08h", d, id, addr[id*XLEN +: XLEN]);
  endtask

  initial begin
    ben   = '{default: '0};
    sack  = '{default: 1'b0};
    srd   = '0;
    wr_en = 4'b0101;
    atomic = '0;
    lock   = '0;
    oper   = '0;
    byte_en = 16'h8C31;
    for (int m = 0; m < 4; m++) begin
      addr[m*XLEN +: XLEN]    = 32'h1000 + 32'(m * 16);
      wr_data[m*XLEN +: XLEN] = 32'hA000 + 32'(m);
    end

    // Reset: outputs zero, slave ack ignored.
    repeat (3) tick;
    sack[0] = 1'b1;
    srd     = 32'hFFFF_FFFF;
    #1;
    chk("rst_bus_en", 64'(o_ben[0]), 64'd0);
    chk("rst_id", 64'(o_id[0]), 64'd0);
    chk("rst_ack", 64'(o_ack[0]), 64'd0);
    chk("rst_addr", 64'(o_addr[0]), 64'd0);
    chk("rst_rd", 64'(o_rd[0]), 64'd0);
    sack[0] = 1'b0;
    rst = 1'b0;
    tick;

    // RR: masters 1 and 3 from reset -> 1 then 3.
    ben[0] = 4'b1010;
    txn(0, 1, 1'b1);
    txn(0, 3, 1'b1);

    // RR: all four continuously -> 0,1,2,3,0.
    ben[0] = 4'b1111;
    for (int k = 0; k < 5; k++) txn(0, k % 4, 1'b0);
    ben[0] = 4'b0000;
    tick;

    // Lock: master 2 LR with lock (pointer now 1), master 0 waiting.
    ben[0] = 4'b0101;
    lock[2] = 1'b1;
    atomic[2] = 1'b1;
    oper[2*7 +: 7] = 7'h2F;
    txn(0, 2, 1'b1);
    lock[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("lock_hold", 64'(o_ben[0]), 64'd0);
    end
    ben[0][2] = 1'b1;
    txn(0, 2, 1'b1);
    txn(0, 0, 1'b1);

    // Stability: address change and request drop mid-BUSY are ignored.
    addr[1*XLEN +: XLEN] = 32'h100;
    ben[0] = 4'b0010;
    tick;
    chk("stab_busy", 64'(o_ben[0]), 64'd1);
    chk("stab_addr0", 64'(o_addr[0]), 64'h100);
    addr[1*XLEN +: XLEN] = 32'h200;
    ben[0] = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      tick;
      chk("stab_addr", 64'(o_addr[0]), 64'h100);
      chk("stab_hold", 64'(o_ben[0]), 64'd1);
      chk("stab_noack", 64'(o_ack[0]), 64'd0);
    end
    sack[0] = 1'b1;
    srd = 32'h5A5A_0001;
    #1;
    chk("stab_ack", 64'(o_ack[0]), 64'b0010);
    tick;
    sack[0] = 1'b0;
    chk("stab_idle", 64'(o_ben[0]), 64'd0);
    $display("txn dut0 master1 addr=00000100 (stability)");
    addr[1*XLEN +: XLEN] = 32'h1010;

    // Slave ack while IDLE: no o_ack, no transaction.
    sack[0] = 1'b1;
    srd = 32'h1234;
    #1;
    chk("idle_ack", 64'(o_ack[0]), 64'd0);
    chk("idle_rd", 64'(o_rd[0]), 64'd0);
    tick;
    chk("idle_nobus", 64'(o_ben[0]), 64'd0);
    sack[0] = 1'b0;

    // FIXED: masters 0 and 2 -> always 0; 2 only after 0 leaves.
    ben[1] = 4'b0101;
    for (int k = 0; k < 3; k++) txn(1, 0, 1'b0);
    ben[1][0] = 1'b0;
    txn(1, 2, 1'b1);

    // N=3 RR: all requesting -> 0,1,2 then wrap to 0.
    ben[2] = 4'b0111;
    for (int k = 0; k < 4; k++) txn(2, k % 3, 1'b0);
    ben[2] = 4'b0000;
    tick;

    // Async reset during BUSY with a slow slave.
    ben[0] = 4'b1000;
    tick;
    chk("rb_busy", 64'(o_ben[0]), 64'd1);
    chk("rb_id", 64'(o_id[0]), 64'd3);
    tick;
    rst = 1'b1;
    sack[0] = 1'b1;
    #1;
    chk("rb_bus_en", 64'(o_ben[0]), 64'd0);
    chk("rb_id0", 64'(o_id[0]), 64'd0);
    chk("rb_addr", 64'(o_addr[0]), 64'd0);
    chk("rb_ack", 64'(o_ack[0]), 64'd0);
    ben[0] = 4'b0000;
    tick;
    rst = 1'b0;
    tick;
    chk("rb_post_ack", 64'(o_ack[0]), 64'd0);
    chk("rb_post_bus", 64'(o_ben[0]), 64'd0);
    sack[0] = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
